// File: rtl/core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : core_fetch
// Brief    : Instruction fetch stage. Owns the PC, issues in-order IMEM
//            requests under a credit limit, buffers returned words and
//            presents one instruction per cycle to decode.
// Revision : 1.0 - initial release
// ============================================================================
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        STALL,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_GNT,
    input  logic        IMEM_RVALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INST,
    output logic [31:0] INST_PC,
    output logic        INST_VALID
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                 c_CNT_W    = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W:0]   c_CREDITS  = (c_CNT_W + 1)'(DEPTH);
    localparam logic [31:0]        c_NOP      = 32'h0000_0013;

    logic [31:0]        r_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] r_discard;

    logic [31:0]        r_fifo_data [DEPTH];
    logic [31:0]        r_fifo_pc   [DEPTH];
    logic [c_PTR_W-1:0] r_fifo_rd;
    logic [c_PTR_W-1:0] r_fifo_wr;
    logic [c_CNT_W-1:0] r_fifo_count;

    logic [31:0]        r_aq_pc [DEPTH];
    logic [c_PTR_W-1:0] r_aq_rd;
    logic [c_PTR_W-1:0] r_aq_wr;

    logic [c_CNT_W:0]   w_credit_used;
    logic [c_CNT_W-1:0] w_out_next;
    logic [31:0]        w_redirect_pc;
    logic               w_grant;
    logic               w_rsp;
    logic               w_rsp_drop;
    logic               w_push;
    logic               w_pop;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Buffered words count against the credit so the FIFO can never overflow.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, r_fifo_count};
    assign IMEM_REQ      = RST_N && !REDIRECT && (w_credit_used < c_CREDITS);
    assign IMEM_ADDR     = r_pc;
    assign w_grant       = IMEM_REQ && IMEM_GNT;
    assign w_redirect_pc = REDIRECT_PC & 32'hFFFF_FFFC;

    // Responses with nothing outstanding are strays and have no effect at all.
    assign w_rsp      = IMEM_RVALID && (r_outstanding != '0);
    assign w_rsp_drop = w_rsp && (r_discard != '0);
    assign w_push     = w_rsp && (r_discard == '0) && !REDIRECT;
    assign w_out_next = r_outstanding + c_CNT_W'(w_grant) - c_CNT_W'(w_rsp);

    assign INST_VALID = RST_N && !REDIRECT && (r_fifo_count != '0);
    assign w_pop      = INST_VALID && !STALL;
    assign INST       = INST_VALID ? r_fifo_data[r_fifo_rd] : c_NOP;
    assign INST_PC    = INST_VALID ? r_fifo_pc[r_fifo_rd]   : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_pc          <= {RESET_PC[31:2], 2'b00};
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (REDIRECT) begin
                // Everything still in flight after this edge belongs to the old stream.
                r_pc      <= w_redirect_pc;
                r_discard <= w_out_next;
            end else begin
                if (w_grant) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp_drop) begin
                    r_discard <= r_discard - c_CNT_W'(1);
                end
            end
        end
    end

    // Address queue holds the PC of each live (non-discarded) request in order.
    always_ff @(posedge CLK) begin
        if (!RST_N || REDIRECT) begin
            r_aq_rd <= '0;
            r_aq_wr <= '0;
        end else begin
            if (w_grant) begin
                r_aq_wr <= f_ptr_inc(r_aq_wr);
            end
            if (w_push) begin
                r_aq_rd <= f_ptr_inc(r_aq_rd);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_grant) begin
            r_aq_pc[r_aq_wr] <= r_pc;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || REDIRECT) begin
            r_fifo_rd    <= '0;
            r_fifo_wr    <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wr <= f_ptr_inc(r_fifo_wr);
            end
            if (w_pop) begin
                r_fifo_rd <= f_ptr_inc(r_fifo_rd);
            end
            r_fifo_count <= r_fifo_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_data[r_fifo_wr] <= IMEM_RDATA;
            r_fifo_pc[r_fifo_wr]   <= r_aq_pc[r_aq_rd];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_fetch
// Brief    : Directed and randomised-memory bench for core_fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        STALL = 1'b0;
    logic        REDIRECT = 1'b0;
    logic [31:0] REDIRECT_PC = '0;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT = 1'b0;
    logic        IMEM_RVALID = 1'b0;
    logic [31:0] IMEM_RDATA = '0;
    logic [31:0] INST;
    logic [31:0] INST_PC;
    logic        INST_VALID;

    int n_checks = 0;
    int n_fail   = 0;

    core_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .REDIRECT(REDIRECT),
        .REDIRECT_PC(REDIRECT_PC), .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
        .IMEM_GNT(IMEM_GNT), .IMEM_RVALID(IMEM_RVALID), .IMEM_RDATA(IMEM_RDATA),
        .INST(INST), .INST_PC(INST_PC), .INST_VALID(INST_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[17:2], ~a[17:2]};
    endfunction

    // In-order memory: grants sampled at posedge, responses driven at negedge.
    typedef struct { logic [31:0] data; int due; } rsp_t;
    rsp_t rq[$];
    int cyc = 0;
    int last_due = 0;
    int lat_min = 1;
    int lat_max = 1;
    int gnt_pct = 100;

    always @(posedge CLK) begin : model_grant
        int d;
        cyc = cyc + 1;
        if (IMEM_REQ && IMEM_GNT) begin
            d = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            rq.push_back('{data: mem_word(IMEM_ADDR), due: d});
        end
    end

    always @(negedge CLK) begin : model_rsp
        IMEM_GNT = (int'($urandom_range(99, 0)) < gnt_pct);
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            IMEM_RVALID = 1'b1;
            IMEM_RDATA  = rq[0].data;
            void'(rq.pop_front());
        end else begin
            IMEM_RVALID = 1'b0;
            IMEM_RDATA  = '0;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) tick();
        n_checks++; if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", IMEM_REQ); end
        n_checks++; if (INST_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", INST_VALID); end
        n_checks++; if (INST !== NOP) begin n_fail++; $display("FAIL reset_inst: got %h want %h", INST, NOP); end
        n_checks++; if (INST_PC !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h want 0", INST_PC); end
        n_checks++; if (IMEM_ADDR !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", IMEM_ADDR, RESET_PC); end
    endtask

    task automatic test_startup();
        logic [31:0] exp_pc, exp_addr;
        RST_N = 1'b1;
        #1;
        n_checks++; if (IMEM_REQ !== 1'b1) begin n_fail++; $display("FAIL start_req: got %b want 1", IMEM_REQ); end
        n_checks++; if (IMEM_ADDR !== 32'h0) begin n_fail++; $display("FAIL start_addr0: got %h want 0", IMEM_ADDR); end
        tick();
        n_checks++; if (INST_VALID !== 1'b0) begin n_fail++; $display("FAIL start_valid_early: got %b want 0", INST_VALID); end
        n_checks++; if (IMEM_ADDR !== 32'h4) begin n_fail++; $display("FAIL start_addr1: got %h want 4", IMEM_ADDR); end
        tick();
        n_checks++; if (INST_VALID !== 1'b1) begin n_fail++; $display("FAIL start_first_valid: got %b want 1", INST_VALID); end
        n_checks++; if (INST_PC !== 32'h0) begin n_fail++; $display("FAIL start_first_pc: got %h want 0", INST_PC); end
        n_checks++; if (INST !== mem_word(32'h0)) begin n_fail++; $display("FAIL start_first_inst: got %h want %h", INST, mem_word(32'h0)); end
        exp_pc = 32'h4;
        exp_addr = 32'h8;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (IMEM_REQ === 1'b1) begin
                n_checks++; if (IMEM_ADDR !== exp_addr) begin n_fail++; $display("FAIL start_addr_seq: got %h want %h", IMEM_ADDR, exp_addr); end
                exp_addr += 32'd4;
            end
            if (INST_VALID === 1'b1) begin
                n_checks++; if (INST_PC !== exp_pc) begin n_fail++; $display("FAIL start_pc_seq: got %h want %h", INST_PC, exp_pc); end
                n_checks++; if (INST !== mem_word(exp_pc)) begin n_fail++; $display("FAIL start_inst_seq: got %h want %h", INST, mem_word(exp_pc)); end
                exp_pc += 32'd4;
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] held_pc, held_inst, exp_pc;
        int got;
        for (int i = 0; i < 10 && INST_VALID !== 1'b1; i++) tick();
        n_checks++; if (INST_VALID !== 1'b1) begin n_fail++; $display("FAIL stall_wait_valid: got %b want 1", INST_VALID); end
        held_pc = INST_PC;
        held_inst = INST;
        STALL = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++; if (INST_VALID !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", INST_VALID); end
            n_checks++; if (INST_PC !== held_pc) begin n_fail++; $display("FAIL stall_pc_hold: got %h want %h", INST_PC, held_pc); end
            n_checks++; if (INST !== held_inst) begin n_fail++; $display("FAIL stall_inst_hold: got %h want %h", INST, held_inst); end
            if (k >= 2) begin
                n_checks++; if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL stall_credit_req: got %b want 0", IMEM_REQ); end
            end
        end
        STALL = 1'b0;
        #1;
        exp_pc = held_pc;
        got = 0;
        for (int i = 0; i < 40 && got < 6; i++) begin
            if (INST_VALID === 1'b1) begin
                n_checks++; if (INST_PC !== exp_pc) begin n_fail++; $display("FAIL stall_release_pc: got %h want %h", INST_PC, exp_pc); end
                n_checks++; if (INST !== mem_word(exp_pc)) begin n_fail++; $display("FAIL stall_release_inst: got %h want %h", INST, mem_word(exp_pc)); end
                exp_pc += 32'd4;
                got++;
            end
            tick();
        end
        n_checks++; if (got != 6) begin n_fail++; $display("FAIL stall_release_timeout: got %0d instructions want 6", got); end
    endtask

    // Waits for the first instruction of a new stream and checks a short run of it.
    task automatic expect_stream(input string name, input logic [31:0] start_pc);
        logic [31:0] exp_pc;
        int got;
        exp_pc = start_pc;
        got = 0;
        for (int i = 0; i < 40 && got < 3; i++) begin
            if (INST_VALID === 1'b1) begin
                n_checks++; if (INST_PC !== exp_pc) begin n_fail++; $display("FAIL %s_pc: got %h want %h", name, INST_PC, exp_pc); end
                n_checks++; if (INST !== mem_word(exp_pc)) begin n_fail++; $display("FAIL %s_inst: got %h want %h", name, INST, mem_word(exp_pc)); end
                exp_pc += 32'd4;
                got++;
            end
            tick();
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL %s_timeout: got %0d instructions want 3", name, got); end
    endtask

    task automatic test_redirect();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30 && rq.size() != 2; i++) tick();
        n_checks++; if (rq.size() != 2) begin n_fail++; $display("FAIL redir_inflight: got %0d want 2", rq.size()); end
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0103;
        #1;
        n_checks++; if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL redir_cycle_req: got %b want 0", IMEM_REQ); end
        n_checks++; if (INST_VALID !== 1'b0) begin n_fail++; $display("FAIL redir_cycle_valid: got %b want 0", INST_VALID); end
        n_checks++; if (INST !== NOP) begin n_fail++; $display("FAIL redir_cycle_inst: got %h want %h", INST, NOP); end
        tick();
        REDIRECT = 1'b0;
        #1;
        n_checks++; if (IMEM_ADDR !== 32'h0000_0100) begin n_fail++; $display("FAIL redir_addr: got %h want 00000100", IMEM_ADDR); end
        expect_stream("redir", 32'h0000_0100);
    endtask

    task automatic test_redirect_same_cycle();
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 30 && !(rq.size() > 0 && rq[0].due <= cyc && IMEM_REQ === 1'b1); i++) tick();
        n_checks++; if (!(rq.size() > 0 && rq[0].due <= cyc)) begin n_fail++; $display("FAIL same_wait_rvalid: got %0d pending want >0", rq.size()); end
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0200;
        #1;
        n_checks++; if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL same_cycle_req: got %b want 0", IMEM_REQ); end
        tick();
        REDIRECT = 1'b0;
        #1;
        n_checks++; if (IMEM_ADDR !== 32'h0000_0200) begin n_fail++; $display("FAIL same_addr: got %h want 00000200", IMEM_ADDR); end
        expect_stream("same", 32'h0000_0200);
    endtask

    task automatic test_back_to_back();
        lat_min = 2; lat_max = 2;
        for (int i = 0; i < 30 && rq.size() == 0; i++) tick();
        REDIRECT = 1'b1;
        REDIRECT_PC = 32'h0000_0300;
        tick();
        REDIRECT_PC = 32'h0000_0404;
        #1;
        n_checks++; if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL b2b_req: got %b want 0", IMEM_REQ); end
        tick();
        REDIRECT = 1'b0;
        #1;
        n_checks++; if (IMEM_ADDR !== 32'h0000_0404) begin n_fail++; $display("FAIL b2b_addr: got %h want 00000404", IMEM_ADDR); end
        expect_stream("b2b", 32'h0000_0404);
    endtask

    task automatic test_random();
        logic [31:0] exp_pc, tgt;
        int got, cycles;
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        tgt = 32'h0000_1000;
        REDIRECT = 1'b1;
        REDIRECT_PC = tgt;
        tick();
        REDIRECT = 1'b0;
        exp_pc = tgt;
        got = 0;
        cycles = 0;
        while (got < 200 && cycles < 5000) begin
            n_checks++; if (rq.size() > DEPTH) begin n_fail++; $display("FAIL rand_credit: got %0d in flight want <=%0d", rq.size(), DEPTH); end
            STALL = (int'($urandom_range(99, 0)) < 20);
            if (got > 5 && int'($urandom_range(99, 0)) < 2) begin
                tgt = 32'($urandom_range(32'h0003_FFFF, 0));
                REDIRECT_PC = tgt;
                REDIRECT = 1'b1;
            end
            #1;
            if (INST_VALID === 1'b1 && STALL === 1'b0) begin
                n_checks++; if (INST_PC !== exp_pc) begin n_fail++; $display("FAIL rand_pc: got %h want %h", INST_PC, exp_pc); end
                n_checks++; if (INST !== mem_word(INST_PC)) begin n_fail++; $display("FAIL rand_inst: got %h want %h", INST, mem_word(INST_PC)); end
                exp_pc += 32'd4;
                got++;
            end
            if (REDIRECT === 1'b1) exp_pc = tgt & 32'hFFFF_FFFC;
            tick();
            REDIRECT = 1'b0;
            cycles++;
        end
        n_checks++; if (got != 200) begin n_fail++; $display("FAIL rand_timeout: got %0d instructions want 200", got); end
        STALL = 1'b0;
        gnt_pct = 100;
    endtask

    task automatic test_reset_midflight();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 30 && rq.size() != 2; i++) tick();
        n_checks++; if (rq.size() != 2) begin n_fail++; $display("FAIL mid_inflight: got %0d want 2", rq.size()); end
        RST_N = 1'b0;
        #1;
        n_checks++; if (IMEM_REQ !== 1'b0) begin n_fail++; $display("FAIL mid_reset_req: got %b want 0", IMEM_REQ); end
        n_checks++; if (INST_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", INST_VALID); end
        n_checks++; if (INST !== NOP) begin n_fail++; $display("FAIL mid_reset_inst: got %h want %h", INST, NOP); end
        n_checks++; if (INST_PC !== 32'h0) begin n_fail++; $display("FAIL mid_reset_pc: got %h want 0", INST_PC); end
        tick();
        // Abandoned requests collapse into one stray response right after release.
        rq.delete();
        rq.push_back('{data: 32'hDEAD_BEEF, due: cyc});
        last_due = cyc;
        RST_N = 1'b1;
        #1;
        n_checks++; if (IMEM_ADDR !== RESET_PC) begin n_fail++; $display("FAIL mid_restart_addr: got %h want %h", IMEM_ADDR, RESET_PC); end
        n_checks++; if (INST_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_restart_valid: got %b want 0", INST_VALID); end
        expect_stream("mid_restart", RESET_PC);
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect();
        test_redirect_same_cycle();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
